// File: rtl/mdu_unit.sv
// mdu_unit: multi-cycle multiply/divide unit with HI/LO registers.
//
// A launch in IDLE latches the operands and the operation. The block then
// stays busy for MULT_CYCLES (mult/multu) or DIV_CYCLES (div/divu) cycles.
// The result is written to HI/LO on the completion edge.
//
// Ports:
//   clk            single clock; all state updates on the rising edge
//   reset          synchronous active-high reset
//   start, op      launch request; op: 00 mult, 01 multu, 10 div, 11 divu
//   a, b           rs operand / dividend, rt operand / divisor
//   we_hi, we_lo   mthi / mtlo write strobes, data on wdata
//   busy           operation in progress
//   hi, lo         HI / LO architectural registers
module mdu_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        we_hi,
    input  logic        we_lo,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic [1:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        busy_q;

    // Combinational datapath results, consumed only on the completion edge.
    logic        signed_op_s;
    logic        div_zero_s;
    logic [63:0] mul_a_s;
    logic [63:0] mul_b_s;
    logic [63:0] prod_s;
    logic        a_neg_s;
    logic        b_neg_s;
    logic [31:0] a_mag_s;
    logic [31:0] b_mag_s;
    logic [31:0] q_mag_s;
    logic [31:0] r_mag_s;
    logic [31:0] quot_s;
    logic [31:0] rem_s;
    logic [31:0] res_hi_s;
    logic [31:0] res_lo_s;

    // Shared multiplier and divider datapath.
    // op[0] clear selects the signed variant for both mult and div.
    always_comb begin
        signed_op_s = ~op_q[0];
        div_zero_s  = op_q[1] & (b_q == 32'd0);

        // Sign- or zero-extending to 64 bits lets one unsigned multiply
        // produce the correct low 64 bits of either product.
        mul_a_s = {{32{signed_op_s & a_q[31]}}, a_q};
        mul_b_s = {{32{signed_op_s & b_q[31]}}, b_q};
        prod_s  = mul_a_s * mul_b_s;

        // The signed divide works on magnitudes. This keeps 0x80000000 / -1
        // well defined: the magnitude quotient 0x80000000, negated, wraps
        // back to itself.
        a_neg_s = signed_op_s & a_q[31];
        b_neg_s = signed_op_s & b_q[31];
        a_mag_s = a_neg_s ? (32'd0 - a_q) : a_q;
        b_mag_s = b_neg_s ? (32'd0 - b_q) : b_q;
        // The divisor is forced non-zero to keep the divider well defined.
        // A zero-divisor result is discarded at completion.
        b_mag_s = (b_mag_s == 32'd0) ? 32'd1 : b_mag_s;
        q_mag_s = a_mag_s / b_mag_s;
        r_mag_s = a_mag_s % b_mag_s;
        quot_s  = (a_neg_s ^ b_neg_s) ? (32'd0 - q_mag_s) : q_mag_s;
        rem_s   = a_neg_s ? (32'd0 - r_mag_s) : r_mag_s;

        res_hi_s = hi_q;
        res_lo_s = lo_q;
        case (op_q[1])
            1'b0: begin
                res_hi_s = prod_s[63:32];
                res_lo_s = prod_s[31:0];
            end
            1'b1: begin
                res_hi_s = rem_s;
                res_lo_s = quot_s;
            end
            default: begin
                res_hi_s = hi_q;
                res_lo_s = lo_q;
            end
        endcase
    end

    // Control FSM together with the operand, counter and HI/LO registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            op_q    <= 2'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        // A launch takes priority over same-cycle mthi/mtlo.
                        op_q    <= op;
                        a_q     <= a;
                        b_q     <= b;
                        cnt_q   <= op[1] ? DIV_CNT : MULT_CNT;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end else begin
                        if (we_hi) begin
                            hi_q <= wdata;
                        end
                        if (we_lo) begin
                            lo_q <= wdata;
                        end
                    end
                end
                ST_RUN: begin
                    // start, we_* and a/b are deliberately not looked at here.
                    // <= 1 also terminates a degenerate zero-cycle setting.
                    if (cnt_q <= 4'd1) begin
                        cnt_q   <= 4'd0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                        if (!div_zero_s) begin
                            hi_q <= res_hi_s;
                            lo_q <= res_lo_s;
                        end
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: begin
                    cnt_q   <= 4'd0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
